fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 68 ++++++
 tb/tb_fetch_stage.sv | 114 +++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a single outstanding SRAM-like request,
// a one-entry hold buffer for stage-2 stalls, and redirect cancellation.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'hBFC00000,
  parameter int          BUS_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             inst_req,
  output logic [31:0]      inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [31:0]      inst_rdata,
  input  logic             br_taken_in,
  input  logic [31:0]      br_target_in,
  input  logic             stage2_allowin_in,
  output logic             stage1_to_stage2_valid_out,
  output logic [BUS_W-1:0] stage1_to_stage2_bus_out
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_buf_q, inst_buf_d;
  logic        cancel_q, cancel_d, handoff;
  assign inst_req  = (state_q == S_REQ) && rst;
  assign inst_addr = pc_q;
  assign stage1_to_stage2_valid_out = rst && ((state_q == S_HOLD) ||
                                      ((state_q == S_WAIT) && inst_data_ok && !cancel_q));
  assign stage1_to_stage2_bus_out = rst ?
    {pc_q, (state_q == S_HOLD) ? inst_buf_q : inst_rdata} : '0;
  assign handoff = stage1_to_stage2_valid_out && stage2_allowin_in;
  always_comb begin
    pc_d       = br_taken_in ? br_target_in : handoff ? pc_q + 32'd4 : pc_q;
    state_d    = state_q;
    cancel_d   = cancel_q;
    inst_buf_d = inst_buf_q;
    case (state_q)
      S_REQ: begin
        // an accepted request is for the old pc if a redirect lands in the same cycle
        state_d  = inst_addr_ok ? S_WAIT : S_REQ;
        cancel_d = inst_addr_ok ? br_taken_in : cancel_q;
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          state_d    = (cancel_q || handoff || br_taken_in) ? S_REQ : S_HOLD;
          cancel_d   = 1'b0;
          inst_buf_d = (cancel_q || handoff || br_taken_in) ? inst_buf_q : inst_rdata;
        end else begin
          cancel_d = cancel_q || br_taken_in;
        end
      end
      S_HOLD:  state_d = (handoff || br_taken_in) ? S_REQ : S_HOLD;
      default: state_d = S_REQ;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_REQ;
      pc_q       <= PC_RESET;
      cancel_q   <= 1'b0;
      inst_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cancel_q   <= cancel_d;
      inst_buf_q <= inst_buf_d;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed per-cycle vectors; expected control/bus values and
// expected handoffs are queued by the stimulus and checked by a monitor.
module tb_fetch_stage;
  localparam logic [31:0] B = 32'hBFC00000;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic        cb;
    logic [63:0] bus;
  } rec_t;
  logic        clk = 1'b0, rst = 1'b0;
  logic        inst_req, inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic [31:0] inst_addr, inst_rdata = '0, br_target_in = '0;
  logic        br_taken_in = 1'b0, stage2_allowin_in = 1'b0, valid_out;
  logic [63:0] bus_out;
  logic        done = 1'b0;
  int          vec = 0, miss = 0;
  rec_t        cq[$];
  logic [63:0] hq[$];
  always #5 clk = ~clk;
  fetch_stage dut (
    .clk(clk), .rst(rst), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .br_taken_in(br_taken_in), .br_target_in(br_target_in),
    .stage2_allowin_in(stage2_allowin_in),
    .stage1_to_stage2_valid_out(valid_out), .stage1_to_stage2_bus_out(bus_out)
  );
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic rs, input logic aok, input logic dok, input logic [31:0] rd,
                     input logic br, input logic [31:0] tgt, input logic al,
                     input logic ereq, input logic [31:0] eaddr, input logic ev,
                     input logic [63:0] ebus);
    rec_t r;
    @(posedge clk);
    #1;
    rst = rs; inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rd;
    br_taken_in = br; br_target_in = tgt; stage2_allowin_in = al;
    r.req = ereq; r.addr = eaddr; r.valid = ev; r.cb = ev || !rs; r.bus = ebus;
    cq.push_back(r);
    if (ev && al) hq.push_back(ebus);
  endtask
  always @(negedge clk) begin
    rec_t r;
    if (cq.size() > 0) begin
      r = cq.pop_front();
      chk("inst_req", {63'd0, inst_req}, {63'd0, r.req});
      chk("inst_addr", {32'd0, inst_addr}, {32'd0, r.addr});
      chk("valid_out", {63'd0, valid_out}, {63'd0, r.valid});
      if (r.cb) chk("bus_out", bus_out, r.bus);
    end
    if (valid_out && stage2_allowin_in) begin
      if (hq.size() == 0) chk("unexpected_handoff", bus_out, 64'hX);
      else chk("handoff_bus", bus_out, hq.pop_front());
    end
    if (done) begin
      chk("pending_handoffs", 64'(hq.size()), 64'd0);
      chk("pending_cycles", 64'(cq.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
    end
  end
  initial begin
    cyc(0,0,0,0,0,0,0, 0,B,0,64'd0);
    cyc(0,0,0,0,0,0,0, 0,B,0,64'd0);
    cyc(1,1,0,0,0,0,0, 1,B,0,64'd0);
    cyc(1,0,1,32'h24080001,0,0,1, 0,B,1,{B,32'h24080001});
    cyc(1,1,0,0,0,0,0, 1,B+4,0,64'd0);
    cyc(1,0,1,32'h00000000,0,0,0, 0,B+4,1,{B+32'd4,32'h0});
    cyc(1,0,0,32'hFFFFFFFF,0,0,0, 0,B+4,1,{B+32'd4,32'h0});
    cyc(1,0,0,32'hFFFFFFFF,0,0,0, 0,B+4,1,{B+32'd4,32'h0});
    cyc(1,0,0,32'hFFFFFFFF,0,0,1, 0,B+4,1,{B+32'd4,32'h0});
    cyc(1,1,0,0,0,0,0, 1,B+8,0,64'd0);
    cyc(1,0,0,0,1,B+32'h100,0, 0,B+8,0,64'd0);
    cyc(1,0,0,0,0,0,0, 0,B+32'h100,0,64'd0);
    cyc(1,0,1,32'h11111111,0,0,1, 0,B+32'h100,0,64'd0);
    cyc(1,1,0,0,0,0,0, 1,B+32'h100,0,64'd0);
    cyc(1,0,1,32'h22222222,1,B+32'h200,1, 0,B+32'h100,1,{B+32'h100,32'h22222222});
    cyc(1,0,0,0,0,0,0, 1,B+32'h200,0,64'd0);
    cyc(1,0,0,0,1,B+32'h300,0, 1,B+32'h200,0,64'd0);
    cyc(1,0,0,0,0,0,0, 1,B+32'h300,0,64'd0);
    cyc(1,0,0,0,0,0,0, 1,B+32'h300,0,64'd0);
    cyc(1,1,0,0,0,0,0, 1,B+32'h300,0,64'd0);
    cyc(1,0,1,32'h33333333,0,0,1, 0,B+32'h300,1,{B+32'h300,32'h33333333});
    cyc(1,1,0,0,0,0,0, 1,B+32'h304,0,64'd0);
    cyc(1,0,1,32'h44444444,0,0,0, 0,B+32'h304,1,{B+32'h304,32'h44444444});
    cyc(1,0,0,0,0,0,0, 0,B+32'h304,1,{B+32'h304,32'h44444444});
    cyc(0,0,0,0,0,0,0, 0,B,0,64'd0);
    cyc(0,0,0,0,0,0,0, 0,B,0,64'd0);
    cyc(1,0,0,0,0,0,0, 1,B,0,64'd0);
    cyc(1,1,0,0,0,0,0, 1,B,0,64'd0);
    cyc(1,0,1,32'h55555555,0,0,1, 0,B,1,{B,32'h55555555});
    cyc(1,0,0,0,1,32'hFFFFFFFC,0, 1,B+4,0,64'd0);
    cyc(1,1,0,0,0,0,0, 1,32'hFFFFFFFC,0,64'd0);
    cyc(1,0,1,32'h66666666,0,0,1, 0,32'hFFFFFFFC,1,{32'hFFFFFFFC,32'h66666666});
    cyc(1,1,0,0,0,0,0, 1,32'h0,0,64'd0);
    cyc(1,0,1,32'h77777777,0,0,0, 0,32'h0,1,{32'h0,32'h77777777});
    cyc(1,0,0,0,1,B+32'h400,0, 0,32'h0,1,{32'h0,32'h77777777});
    cyc(1,0,0,0,0,0,0, 1,B+32'h400,0,64'd0);
    cyc(1,1,0,0,1,B+32'h500,0, 1,B+32'h400,0,64'd0);
    cyc(1,0,1,32'h88888888,0,0,1, 0,B+32'h500,0,64'd0);
    cyc(1,0,0,0,0,0,0, 1,B+32'h500,0,64'd0);
    @(posedge clk);
    #1;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; br_taken_in = 1'b0; stage2_allowin_in = 1'b0;
    done = 1'b1;
  end
endmodule
